// File: rtl/uart_rx_line_buffer_pkg.sv
// Shared ASCII control codes, FSM state encoding and byte classifier for the UART RX line buffer.
package uart_rx_line_buffer_pkg;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_DEL = 8'h7F;

    typedef enum logic {
        StFill  = 1'b0,
        StDrain = 1'b1
    } state_e;

    function automatic logic is_erase(input logic [7:0] b);
        return (b == ASCII_BS) || (b == ASCII_DEL);
    endfunction

endpackage

// File: rtl/uart_line_mem.sv
// DEPTH x 8 line store: one synchronous write port, one combinational read port.
module uart_line_mem #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_line_buffer.sv
// Collects UART RX bytes into a line with backspace editing, then drains it on CR as a byte stream.
// Define RX_ECHO_EN to enable local echo of accepted bytes.
module uart_rx_line_buffer
    import uart_rx_line_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      rx_byte,
    input  logic            rx_valid,
    output logic [7:0]      line_data,
    output logic            line_valid,
    input  logic            line_ready,
    output logic            line_last,
    output logic [ADDR_W:0] line_len,
    output logic            overflow,
    output logic            dropped,
    output logic [7:0]      echo_data,
    output logic            echo_valid
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

    state_e            r_state, w_state_d;
    logic [ADDR_W:0]   r_count, w_count_d;
    logic [ADDR_W-1:0] r_rd_ptr, w_rd_ptr_d;
    logic [ADDR_W:0]   r_line_len, w_line_len_d;
    logic              r_ovf, w_ovf_d;
    logic              r_dropped, w_dropped_d;
    logic              w_we;
    logic              w_last;
    logic              w_hs;
    logic [7:0]        w_rdata;
`ifdef RX_ECHO_EN
    logic              r_echo_valid, w_echo_valid_d;
    logic [7:0]        r_echo_data, w_echo_data_d;
    logic              r_lf_pending, w_lf_pending_d;
`endif

    uart_line_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (r_count[ADDR_W-1:0]),
        .i_wdata (rx_byte),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign w_last = ({1'b0, r_rd_ptr} == (r_line_len - ONE_CNT));
    assign w_hs   = line_valid & line_ready;

    always_comb begin
        w_state_d    = r_state;
        w_count_d    = r_count;
        w_rd_ptr_d   = r_rd_ptr;
        w_line_len_d = r_line_len;
        w_ovf_d      = r_ovf;
        w_dropped_d  = 1'b0;
        w_we         = 1'b0;
`ifdef RX_ECHO_EN
        w_echo_valid_d = r_lf_pending;
        w_echo_data_d  = r_lf_pending ? ASCII_LF : 8'h00;
        w_lf_pending_d = 1'b0;
`endif
        unique case (r_state)
            StFill: begin
                if (rx_valid) begin
                    if (rx_byte == ASCII_CR) begin
                        if (r_count != '0) begin
                            w_line_len_d = r_count;
                            w_rd_ptr_d   = '0;
                            w_state_d    = StDrain;
`ifdef RX_ECHO_EN
                            w_echo_valid_d = 1'b1;
                            w_echo_data_d  = ASCII_CR;
                            w_lf_pending_d = 1'b1;
`endif
                        end
                    end else if (rx_byte == ASCII_LF) begin
                        w_count_d = r_count;
                    end else if (is_erase(rx_byte)) begin
                        if (r_count != '0) begin
                            w_count_d = r_count - ONE_CNT;
`ifdef RX_ECHO_EN
                            w_echo_valid_d = 1'b1;
                            w_echo_data_d  = ASCII_BS;
`endif
                        end
                    end else if (r_count != FULL_CNT) begin
                        w_we      = 1'b1;
                        w_count_d = r_count + ONE_CNT;
`ifdef RX_ECHO_EN
                        w_echo_valid_d = 1'b1;
                        w_echo_data_d  = rx_byte;
`endif
                    end else begin
                        w_ovf_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                // Bytes arriving while a line is pending are lost, even on the final handshake.
                w_dropped_d = rx_valid;
                if (w_hs) begin
                    if (w_last) begin
                        w_state_d    = StFill;
                        w_count_d    = '0;
                        w_ovf_d      = 1'b0;
                        w_line_len_d = '0;
                        w_rd_ptr_d   = '0;
                    end else begin
                        w_rd_ptr_d = r_rd_ptr + ADDR_W'(1);
                    end
                end
            end
            default: w_state_d = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StFill;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_line_len <= '0;
            r_ovf      <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_count    <= w_count_d;
            r_rd_ptr   <= w_rd_ptr_d;
            r_line_len <= w_line_len_d;
            r_ovf      <= w_ovf_d;
            r_dropped  <= w_dropped_d;
        end
    end

`ifdef RX_ECHO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_echo_valid <= 1'b0;
            r_echo_data  <= 8'h00;
            r_lf_pending <= 1'b0;
        end else begin
            r_echo_valid <= w_echo_valid_d;
            r_echo_data  <= w_echo_data_d;
            r_lf_pending <= w_lf_pending_d;
        end
    end

    assign echo_valid = r_echo_valid;
    assign echo_data  = r_echo_data;
`else
    assign echo_valid = 1'b0;
    assign echo_data  = 8'h00;
`endif

    assign line_valid = (r_state == StDrain);
    assign line_data  = line_valid ? w_rdata : 8'h00;
    assign line_last  = line_valid & w_last;
    assign line_len   = r_line_len;
    assign overflow   = line_valid & r_ovf;
    assign dropped    = r_dropped;

endmodule

// File: tb/tb_uart_rx_line_buffer.sv
// Self-checking bench for uart_rx_line_buffer: vector table plus directed multi-cycle sequences.
module tb_uart_rx_line_buffer;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      rx_byte;
    logic            rx_valid;
    logic [7:0]      line_data;
    logic            line_valid;
    logic            line_ready;
    logic            line_last;
    logic [ADDR_W:0] line_len;
    logic            overflow;
    logic            dropped;
    logic [7:0]      echo_data;
    logic            echo_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_rx_line_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .line_data  (line_data),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .line_last  (line_last),
        .line_len   (line_len),
        .overflow   (overflow),
        .dropped    (dropped),
        .echo_data  (echo_data),
        .echo_valid (echo_valid)
    );

    typedef struct {
        logic       v;
        logic [7:0] b;
        logic       rdy;
        logic       lv;
        logic [7:0] ld;
        logic       last;
        logic [5:0] len;
        logic       drp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [7:0] b, input logic rdy,
                                input logic lv, input logic [7:0] ld, input logic last,
                                input logic [5:0] len, input logic drp);
        vec_t r;
        r.v = v; r.b = b; r.rdy = rdy; r.lv = lv; r.ld = ld; r.last = last;
        r.len = len; r.drp = drp;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample outputs well away from the rising edge.
    task automatic cyc(input logic v, input logic [7:0] b, input logic rdy);
        @(negedge clk);
        rx_valid   = v;
        rx_byte    = b;
        line_ready = rdy;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic lv, input logic [7:0] ld,
                           input logic last, input logic [5:0] len, input logic ovf,
                           input logic drp);
        chk({tag, ".line_valid"}, line_valid, lv);
        chk({tag, ".line_data"}, line_data, ld);
        chk({tag, ".line_last"}, line_last, last);
        chk({tag, ".line_len"}, line_len, len);
        chk({tag, ".overflow"}, overflow, ovf);
        chk({tag, ".dropped"}, dropped, drp);
`ifndef RX_ECHO_EN
        chk({tag, ".echo_valid"}, echo_valid, 1'b0);
        chk({tag, ".echo_data"}, echo_data, 8'h00);
`endif
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; line_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_out("reset", 1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // "ab" CR
        vecs.push_back(mk(1, 8'h61, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h62, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h0D, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 8'h61, 0, 2, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 8'h62, 1, 2, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 0));
        // "abc" BS "d" CR -> "abd"
        vecs.push_back(mk(1, 8'h61, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h62, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h63, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h08, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h64, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h0D, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 8'h61, 0, 3, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 8'h62, 0, 3, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 8'h64, 1, 3, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 0));
        // BS on empty line, CR, LF: nothing produced
        vecs.push_back(mk(1, 8'h08, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h0D, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h0A, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 0));
        // "q" DEL "r" CR -> "r"
        vecs.push_back(mk(1, 8'h71, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h7F, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h72, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h0D, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 8'h72, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 0));
        // "s" LF CR -> "s"
        vecs.push_back(mk(1, 8'h73, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h0A, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h0D, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 8'h73, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 0));

        foreach (vecs[i]) begin
            cyc(vecs[i].v, vecs[i].b, vecs[i].rdy);
            chk_out($sformatf("vec%0d", i), vecs[i].lv, vecs[i].ld, vecs[i].last,
                    vecs[i].len, 1'b0, vecs[i].drp);
        end

        // Overflow: DEPTH+2 chars then CR
        for (int i = 0; i < DEPTH + 2; i++) cyc(1'b1, 8'(8'h41 + i), 1'b1);
        cyc(1'b1, 8'h0D, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk_out($sformatf("ovf%0d", i), 1'b1, 8'(8'h41 + i), (i == DEPTH - 1),
                    6'(DEPTH), 1'b1, 1'b0);
        end
        cyc(1'b0, 8'h00, 1'b1);
        chk_out("ovf_after", 1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 1'b0);

        // Byte during stalled drain is dropped; line held stable
        cyc(1'b1, 8'h6D, 1'b0);
        cyc(1'b1, 8'h0D, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk_out("stall0", 1'b1, 8'h6D, 1'b1, 6'd1, 1'b0, 1'b0);
        cyc(1'b1, 8'h78, 1'b0);
        chk_out("stall1", 1'b1, 8'h6D, 1'b1, 6'd1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk_out("stall_drop", 1'b1, 8'h6D, 1'b1, 6'd1, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk_out("stall_drop_end", 1'b1, 8'h6D, 1'b1, 6'd1, 1'b0, 1'b0);
        // Final handshake coincides with an rx byte: byte is dropped
        cyc(1'b1, 8'h6B, 1'b1);
        chk_out("last_rx", 1'b1, 8'h6D, 1'b1, 6'd1, 1'b0, 1'b0);
        cyc(1'b1, 8'h0D, 1'b0);
        chk_out("last_rx_drop", 1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk_out("cr_on_empty", 1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 1'b0);

        // Reset mid-drain
        cyc(1'b1, 8'h70, 1'b0);
        cyc(1'b1, 8'h71, 1'b0);
        cyc(1'b1, 8'h0D, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk_out("pre_rst", 1'b1, 8'h70, 1'b0, 6'd2, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        chk_out("post_rst", 1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 1'b0);
        cyc(1'b1, 8'h7A, 1'b1);
        cyc(1'b1, 8'h0D, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        chk_out("z_line", 1'b1, 8'h7A, 1'b1, 6'd1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        chk_out("z_done", 1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 1'b0);

`ifdef RX_ECHO_EN
        cyc(1'b1, 8'h61, 1'b0);
        chk("echo_idle", echo_valid, 1'b0);
        cyc(1'b1, 8'h08, 1'b0);
        chk("echo_a_v", echo_valid, 1'b1);
        chk("echo_a_d", echo_data, 8'h61);
        cyc(1'b1, 8'h08, 1'b0);
        chk("echo_bs_v", echo_valid, 1'b1);
        chk("echo_bs_d", echo_data, 8'h08);
        cyc(1'b1, 8'h61, 1'b0);
        chk("echo_bs_empty", echo_valid, 1'b0);
        cyc(1'b1, 8'h0D, 1'b0);
        chk("echo_a2_v", echo_valid, 1'b1);
        chk("echo_a2_d", echo_data, 8'h61);
        cyc(1'b0, 8'h00, 1'b0);
        chk("echo_cr_v", echo_valid, 1'b1);
        chk("echo_cr_d", echo_data, 8'h0D);
        chk("echo_cr_lv", line_valid, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("echo_lf_v", echo_valid, 1'b1);
        chk("echo_lf_d", echo_data, 8'h0A);
        cyc(1'b0, 8'h00, 1'b1);
        chk("echo_end_v", echo_valid, 1'b0);
        chk("echo_line", line_data, 8'h61);
        chk("echo_last", line_last, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("echo_fill", line_valid, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
